lcd_bus_scheduler: RTL

- Owns the character-LCD bus (LCD_E/RS/RW/DATA) and sequences every write with real setup, enable-pulse, hold and execution timing.
- Runs the power-up init sequence itself.
- Then shares the bus between two client requesters (e.g. line-1 text writer, line-2 or DAC-value writer) via a req/ack handshake and round-robin arbitration.
- Sits between the text/display formatting blocks and the LCD pins.

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_rr_arbiter.sv | 46 ++++
 rtl/lcd_bus_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the character-LCD bus scheduler:
//   - HD44780-style command constants used by the power-up init sequence
//   - init-table length and index width, plus a lookup function for the table
//   - FSM state encoding
//   - small constant helpers for timing-parameter normalisation
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;

    localparam int unsigned LCD_INIT_LEN = 4;
    localparam int unsigned LCD_IDX_W    = $clog2(LCD_INIT_LEN);

    typedef enum logic [2:0] {
        StPwrup,
        StSetup,
        StEpulse,
        StHold,
        StExec,
        StIdle
    } lcd_state_e;

    function automatic logic [7:0] lcd_init_cmd(input logic [LCD_IDX_W-1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_ENTRY;
            default: cmd = LCD_CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // A timing value of 0 behaves as 1 cycle.
    function automatic int unsigned lcd_min1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_rr_arbiter
// Two-way grant logic for the LCD bus clients.
//   clk, rst    : clock, asynchronous active-low reset
//   i_en        : grants may be issued this cycle (scheduler idle)
//   i_req0/1    : client requests
//   o_gnt0/1    : one-hot grant, combinational
// Default build: round-robin, the pointer moves to the other client on
// every grant and starts favouring client 0.
// LCD_SCHED_FIXED_PRIO_EN defined: client 0 always wins, no pointer.
// ---------------------------------------------------------------------------
module lcd_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef LCD_SCHED_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = clk ^ rst;

    assign o_gnt0 = i_en & i_req0;
    assign o_gnt1 = i_en & i_req1 & ~i_req0;
`else
    // r_ptr = 1 means client 1 wins the next tie
    logic r_ptr;

    assign o_gnt0 = i_en & i_req0 & (~i_req1 | ~r_ptr);
    assign o_gnt1 = i_en & i_req1 & (~i_req0 | r_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (o_gnt0) begin
            r_ptr <= 1'b1;
        end else if (o_gnt1) begin
            r_ptr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/lcd_bus_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_bus_scheduler
// Owns the character-LCD write bus. Runs the power-up init sequence, then
// shares the bus between two clients with a req/ack handshake. Every write
// goes SETUP -> EPULSE -> HOLD -> EXEC with parameterised cycle counts.
//   clk, rst              : clock, asynchronous active-low reset
//   req0/rs0/data0, ack0  : client 0 request, register select, byte, accept
//   req1/rs1/data1, ack1  : client 1 request, register select, byte, accept
//   init_done             : init sequence complete (sticky until reset)
//   busy                  : FSM not idle
//   LCD_E/RS/RW/DATA      : LCD pins, all registered (RW tied low)
// Optional macro LCD_SCHED_FIXED_PRIO_EN selects fixed client-0 priority.
// ---------------------------------------------------------------------------
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 70,
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_EPW   = 2,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_EXEC  = 40,
    parameter int unsigned T_CLR   = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int unsigned P_PWRUP = lcd_min1(T_PWRUP);
    localparam int unsigned P_SETUP = lcd_min1(T_SETUP);
    localparam int unsigned P_EPW   = lcd_min1(T_EPW);
    localparam int unsigned P_HOLD  = lcd_min1(T_HOLD);
    localparam int unsigned P_EXEC  = lcd_min1(T_EXEC);
    localparam int unsigned P_CLR   = lcd_min1(T_CLR);
    localparam int unsigned T_MAX   = lcd_max(lcd_max(lcd_max(P_PWRUP, P_SETUP),
                                                       lcd_max(P_EPW, P_HOLD)),
                                              lcd_max(P_EXEC, P_CLR));
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

    // Terminal counts: each state lasts (value + 1) cycles
    localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(P_PWRUP - 1);
    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(P_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EPW   = CNT_W'(P_EPW - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(P_HOLD - 1);
    localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(P_EXEC - 1);
    localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(P_CLR - 1);
    localparam logic [LCD_IDX_W-1:0] IDX_LAST = LCD_IDX_W'(LCD_INIT_LEN - 1);

    lcd_state_e             r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [LCD_IDX_W-1:0]   r_idx, w_idx_d;
    logic                   r_rs, w_rs_d;
    logic [7:0]             r_data, w_data_d;
    logic                   r_init_done, w_init_done_d;
    logic                   r_ack0, w_ack0_d;
    logic                   r_ack1, w_ack1_d;
    logic                   r_e;
    logic                   r_busy;
    logic                   w_arb_en;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_long;

    assign w_arb_en = (r_state == StIdle) & r_init_done;

    lcd_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_arb_en),
        .i_req0 (req0),
        .i_req1 (req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // Clear Display and Return Home need the long execution wait
    assign w_long = ~r_rs & ((r_data[7:1] == LCD_CMD_CLEAR[7:1]) |
                             (r_data[7:1] == LCD_CMD_HOME[7:1]));

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt + CNT_W'(1);
        w_idx_d       = r_idx;
        w_rs_d        = r_rs;
        w_data_d      = r_data;
        w_init_done_d = r_init_done;
        w_ack0_d      = 1'b0;
        w_ack1_d      = 1'b0;
        unique case (r_state)
            StPwrup: begin
                if (r_cnt == L_PWRUP) begin
                    w_state_d = StSetup;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_rs_d    = 1'b0;
                    w_data_d  = lcd_init_cmd('0);
                end
            end
            StSetup: begin
                if (r_cnt == L_SETUP) begin
                    w_state_d = StEpulse;
                    w_cnt_d   = '0;
                end
            end
            StEpulse: begin
                if (r_cnt == L_EPW) begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end
            end
            StHold: begin
                if (r_cnt == L_HOLD) begin
                    w_state_d = StExec;
                    w_cnt_d   = '0;
                end
            end
            StExec: begin
                if (r_cnt == (w_long ? L_CLR : L_EXEC)) begin
                    w_cnt_d = '0;
                    if (!r_init_done && (r_idx != IDX_LAST)) begin
                        w_state_d = StSetup;
                        w_idx_d   = r_idx + LCD_IDX_W'(1);
                        w_rs_d    = 1'b0;
                        w_data_d  = lcd_init_cmd(r_idx + LCD_IDX_W'(1));
                    end else begin
                        w_state_d     = StIdle;
                        w_init_done_d = 1'b1;
                    end
                end
            end
            StIdle: begin
                w_cnt_d = '0;
                if (w_gnt0) begin
                    w_state_d = StSetup;
                    w_rs_d    = rs0;
                    w_data_d  = data0;
                    w_ack0_d  = 1'b1;
                end else if (w_gnt1) begin
                    w_state_d = StSetup;
                    w_rs_d    = rs1;
                    w_data_d  = data1;
                    w_ack1_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StPwrup;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StPwrup;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_init_done <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_e         <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_idx       <= w_idx_d;
            r_rs        <= w_rs_d;
            r_data      <= w_data_d;
            r_init_done <= w_init_done_d;
            r_ack0      <= w_ack0_d;
            r_ack1      <= w_ack1_d;
            // Decode from next state so E and busy line up with the state register
            r_e         <= (w_state_d == StEpulse);
            r_busy      <= (w_state_d != StIdle);
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign LCD_E     = r_e;
    assign LCD_RS    = r_rs;
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = r_data;

endmodule
